// File: rtl/pc_sequencer_pkg.sv
// pc_ctrl_pkg: run-state type and default sizes shared by the next-PC sequencer files
package pc_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t;
  localparam int PC_W = 10;
  localparam int BR_OFF_W = 6;
  localparam int RS_DEPTH = 4;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/PC-side bundle of the next-PC sequencer
interface pc_sequencer_if #(
  parameter int D = pc_ctrl_pkg::PC_W,
  parameter int OW = pc_ctrl_pkg::BR_OFF_W,
  parameter int RS_DEPTH = pc_ctrl_pkg::RS_DEPTH
);
  logic start;
  logic [D-1:0] prog_ctr;
  logic stall;
  logic halt_req;
  logic br_en;
  logic br_taken;
  logic [OW-1:0] br_offset;
  logic jmp_en;
  logic call_en;
  logic [D-1:0] jmp_addr;
  logic ret_en;
  logic absjump_en;
  logic [D-1:0] target;
  logic running;
  logic halted;
  logic stack_err;
  logic [$clog2(RS_DEPTH):0] rs_depth;
  modport master (
    output start, prog_ctr, stall, halt_req, br_en, br_taken, br_offset,
    output jmp_en, call_en, jmp_addr, ret_en,
    input absjump_en, target, running, halted, stack_err, rs_depth
  );
  modport slave (
    input start, prog_ctr, stall, halt_req, br_en, br_taken, br_offset,
    input jmp_en, call_en, jmp_addr, ret_en,
    output absjump_en, target, running, halted, stack_err, rs_depth
  );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: LIFO of return addresses; push when full and pop when empty are ignored
module return_stack #(
  parameter int D = 10,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [D-1:0]  din,
  output logic [D-1:0]  top,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   depth
);
  logic [D-1:0] mem [DEPTH];
  logic [AW:0] below;
  assign below = depth - 1'b1;
  assign top = mem[below[AW-1:0]];
  assign full = depth == (AW+1)'(DEPTH);
  assign empty = depth == '0;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[depth[AW-1:0]] <= din;
      depth <= depth + 1'b1;
    end else if (pop && !empty) begin
      depth <= depth - 1'b1;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: picks the next fetch address (advance/branch/jump/call/return/hold)
// and runs the IDLE/RUN/HALT program state machine
module pc_sequencer import pc_ctrl_pkg::*; #(
  parameter int D = PC_W,
  parameter int OW = BR_OFF_W,
  parameter int RS_DEPTH = pc_ctrl_pkg::RS_DEPTH
) (
  input logic clk,
  input logic reset,
  pc_sequencer_if.slave bus
);
  seq_state_t state, state_n;
  logic push, pop, clear, full, empty, set_err;
  logic [D-1:0] top, br_tgt;
  assign br_tgt = bus.prog_ctr + {{(D-OW){bus.br_offset[OW-1]}}, bus.br_offset};
  return_stack #(.D(D), .DEPTH(RS_DEPTH)) rs (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .clear(clear),
    .din(bus.prog_ctr + 1'b1),
    .top(top),
    .full(full),
    .empty(empty),
    .depth(bus.rs_depth)
  );
  // Holding the PC means reloading it with its own value; absjump_en=0 is the only way to advance
  always_comb begin
    bus.absjump_en = 1'b1;
    bus.target = bus.prog_ctr;
    state_n = state;
    push = 1'b0;
    pop = 1'b0;
    clear = 1'b0;
    set_err = 1'b0;
    if (state != RUN) begin
      if (bus.start) begin
        bus.target = '0;
        clear = state == HALT;
        state_n = RUN;
      end
    end else if (bus.stall) begin
      state_n = RUN;
    end else if (bus.halt_req) begin
      state_n = HALT;
    end else if (bus.ret_en) begin
      pop = !empty;
      bus.target = empty ? bus.prog_ctr : top;
      set_err = empty;
      state_n = empty ? HALT : RUN;
    end else if (bus.call_en) begin
      push = !full;
      set_err = full;
      bus.target = bus.jmp_addr;
    end else if (bus.jmp_en) begin
      bus.target = bus.jmp_addr;
    end else if (bus.br_en && bus.br_taken) begin
      bus.target = br_tgt;
    end else begin
      bus.absjump_en = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.running <= 1'b0;
      bus.halted <= 1'b0;
      bus.stack_err <= 1'b0;
    end else begin
      state <= state_n;
      bus.running <= state_n == RUN;
      bus.halted <= state_n == HALT;
      bus.stack_err <= bus.stack_err | set_err;
    end
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller sitting between the instruction decoder and the program counter. Each cycle it picks the next fetch address from sequential advance, relative branch, absolute jump, call, return, stall or halt, and drives the PC's `absjump_en`/`target` pair. Call/return use an internal return-address stack. A small run-state machine covers start, halt and restart of the program.

## Interface
- `D`, 10, PC/address width; must match the program counter.
- `OW`, 6, relative-branch offset width (two's complement).
- `RS_DEPTH`, 4, return-stack entries (power of two, ≥2).

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: begin execution from IDLE or HALT.
- `prog_ctr` in D: current PC value, fed back from the program counter.
- `stall` in 1: hold the current PC this cycle.
- `halt_req` in 1: decoded halt instruction.
- `br_en` in 1: decoded conditional relative branch.
- `br_taken` in 1: branch condition flag.
- `br_offset` in OW: signed branch offset.
- `jmp_en` in 1: decoded absolute jump.
- `call_en` in 1: decoded call (absolute).
- `jmp_addr` in D: absolute target for jump and call.
- `ret_en` in 1: decoded return.
- `absjump_en` out 1: to PC; 1 loads `target`, 0 means PC+1.
- `target` out D: to PC.
- `running` out 1: state is RUN.
- `halted` out 1: state is HALT.
- `stack_err` out 1: sticky return-stack overflow or underflow.
- `rs_depth` out $clog2(RS_DEPTH)+1: current stack occupancy.

## Operation
- States: IDLE, RUN, HALT. Reset forces IDLE.
- **Hold rule.** The PC increments whenever `absjump_en=0`. To hold the PC, the block drives `absjump_en=1` with `target=prog_ctr`.
- **IDLE**
  - Holds the PC.
  - `start=1` → `absjump_en=1`, `target=0`, next state RUN.
- **RUN**: decode inputs are evaluated in strict priority. Only the winner acts.
  1. `stall`: hold the PC; no stack change.
  2. `halt_req`: hold the PC; go to HALT.
  3. `ret_en`
     - Stack non-empty: pop; `target` = popped value.
     - Stack empty: hold the PC, set `stack_err`, go to HALT.
  4. `call_en`
     - Push `prog_ctr+1` (mod 2^D); `target=jmp_addr`.
     - Stack full: the push is dropped and `stack_err` is set, but the jump is still taken.
  5. `jmp_en`: `target=jmp_addr`.
  6. `br_en & br_taken`: `target = prog_ctr + sign_extend(br_offset)`, modulo 2^D (wraps silently).
  7. Otherwise: `absjump_en=0` (sequential advance).
- `br_en & ~br_taken` falls through to sequential advance.
- **HALT**
  - Holds the PC.
  - `start=1` → `target=0`, return stack cleared, next state RUN.
  - `stack_err` is cleared only by reset.
- Decode inputs are ignored outside RUN.

## Timing
- `absjump_en` and `target` are combinational from state, stack top and inputs. The PC updates on the next `clk` edge, so control-to-PC latency is 1 cycle.
- State, stack contents, `rs_depth` and `stack_err` update on the same edge.
- Values after reset:
  - state IDLE; `running=0`, `halted=0`.
  - `stack_err=0`, `rs_depth=0`, stack contents 0.
  - `absjump_en=1`, `target=prog_ctr`.
- Reset asserted mid-RUN wins over all inputs: the stack empties and the state returns to IDLE on that edge.
- A call and a return in the same cycle resolve to the return only (per the priority order).
- The return stack is LIFO with full depth usable: `RS_DEPTH` pushes are accepted, and the next one overflows.

## Structure
- Package `pc_ctrl_pkg`:
  - `typedef enum logic [1:0] {IDLE, RUN, HALT} seq_state_t`.
  - Default constants `PC_W=10`, `BR_OFF_W=6`, `RS_DEPTH=4`.
- Sub-module `return_stack`: parameterised LIFO with push/pop/clear, `top`, `full`, `empty`, `depth`. It ignores a push when full and a pop when empty; overflow/underflow reporting stays in `pc_sequencer`.
- Top level: FSM, priority mux, offset adder, sticky error flag.

## Test plan
- Reset, then idle 5 cycles with `prog_ctr=0` → `absjump_en=1`, `target=0` every cycle; `running=0`. Pulse `start` → next cycle `running=1`, and `absjump_en=0` with no decode inputs.
- Branch wrap: `D=10`, `prog_ctr=1020`, `br_en=br_taken=1`, `br_offset=+8` → `target=4`. Then `prog_ctr=3`, `br_offset=-4` (6'b111100) → `target=1023`. With `br_taken=0` → `absjump_en=0`.
- Call/return: call at `prog_ctr=100` with `jmp_addr=500` → `target=500`, `rs_depth=1`. Later `ret_en` → `target=101`, `rs_depth=0`. Nested 3 calls return in reverse order.
- Priority and stall: `stall`, `call_en` and `jmp_en` asserted together at `prog_ctr=42` → `target=42`, `rs_depth` unchanged. Then `call_en` with `ret_en` → pop only.
- Stack errors:
  - 5 calls with `RS_DEPTH=4` → 5th jump taken, `rs_depth=4`, `stack_err=1`.
  - After reset, RUN, `ret_en` on an empty stack → `halted=1`, `stack_err=1`, PC held.
- Halt/restart: `halt_req` at `prog_ctr=77` → PC held at 77 for 10 cycles, `halted=1`. `start` → `target=0`, `rs_depth=0`, RUN. Reset asserted mid-RUN with depth 2 → IDLE, `rs_depth=0`.
